// File: rtl/task_frame_sched.sv
// task_frame_sched: round-robin scheduler that hands a shared processing core
// to one of NUM_REQ task buffers holding a complete frame. A job is granted
// for one S_GRANT cycle, held through S_WAIT until the core reports its last
// output word, then released for one S_RELEASE cycle before the next
// arbitration.
// Optional watchdog: define TASK_SCHED_TIMEOUT_EN to force a release after
// TIMEOUT_CYCLES cycles in S_WAIT, flagged by a one-cycle o_timeout pulse.
module task_frame_sched #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_REQ-1:0]                    i_req,
  input  logic                                  i_output_last,
  output logic [NUM_REQ-1:0]                    o_grant,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_grant_id,
  output logic                                  o_start,
  output logic                                  o_busy,
  output logic                                  o_timeout
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Reject illegal configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("task_frame_sched: NUM_REQ or TIMEOUT_CYCLES out of range");
  end

  logic [1:0]         state;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               start;
  logic               busy;
  logic [ID_W-1:0]    last_grant;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [NUM_REQ-1:0] winner_onehot;

`ifdef TASK_SCHED_TIMEOUT_EN
  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt;
  logic        timeout;
`endif

  // Round-robin pick: scan upward from the index after the last released one.
  always_comb begin
    found         = 1'b0;
    winner        = '0;
    winner_onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    winner_onehot[winner] = 1'b1;
  end

  // Scheduler FSM; every output is registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      grant_id   <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
`ifdef TASK_SCHED_TIMEOUT_EN
      cnt        <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
`ifdef TASK_SCHED_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_GRANT;
            grant    <= winner_onehot;
            grant_id <= winner;
            start    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_GRANT: begin
          state <= S_WAIT;
`ifdef TASK_SCHED_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (i_output_last) begin
            state <= S_RELEASE;
            grant <= '0;
`ifdef TASK_SCHED_TIMEOUT_EN
          end else if (cnt == CNT_LIMIT) begin
            state   <= S_RELEASE;
            grant   <= '0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
`endif
          end
        end
        S_RELEASE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          last_grant <= grant_id;
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant    = grant;
  assign o_grant_id = grant_id;
  assign o_start    = start;
  assign o_busy     = busy;
`ifdef TASK_SCHED_TIMEOUT_EN
  assign o_timeout  = timeout;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_task_frame_sched.sv
// tb_task_frame_sched: randomized scoreboard bench for task_frame_sched.
// The driver models each job as a time interval (grant cycle, wait length,
// release cycle) and pushes the expected outputs for the next cycle; a
// monitor pops and compares them one cycle at a time.
module tb_task_frame_sched;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int TO   = 16;
  localparam int NCYC = 4000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            out_last;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            start;
  logic            busy;
  logic            timeout;

  typedef struct packed {
    logic [N-1:0]    grant;
    logic [ID_W-1:0] gid;
    logic            start;
    logic            busy;
    logic            tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   mon_cyc = 0;

  task_frame_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_output_last(out_last),
    .o_grant      (grant),
    .o_grant_id   (grant_id),
    .o_start      (start),
    .o_busy       (busy),
    .o_timeout    (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, mon_cyc, act, expv);
    end
  endtask

  // Monitor: compare the DUT against the oldest expected entry every cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    mon_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",    int'(grant),    int'(e.grant));
      check("grant_id", int'(grant_id), int'(e.gid));
      check("start",    int'(start),    int'(e.start));
      check("busy",     int'(busy),     int'(e.busy));
      check("timeout",  int'(timeout),  int'(e.tmo));
    end
  end

  // Driver with job-interval reference model.
  initial begin
    int   last, id_hold, g, rel, wl, idle_from, d, r, t;
    bit   job, to, do_rst;
    exp_t e;
    rst = 1'b1; req = '0; out_last = 1'b0;
    last = N - 1; id_hold = 0; g = -10; rel = -10; wl = -10;
    idle_from = 0; job = 0; to = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      do_rst = (c < 3) || ($urandom_range(0, 249) == 0);
      r = $urandom_range(0, 9);
      if (r < 3)      req = '1;
      else if (r < 5) req = '0;
      else            req = N'($urandom);
      if (do_rst) begin
        rst = 1'b1;
        out_last = 1'($urandom);
        job = 0; to = 0; last = N - 1; id_hold = 0;
        idle_from = c + 1;
      end else begin
        rst = 1'b0;
        if (c >= idle_from && req != '0) begin
          id_hold = pick(req, last);
          last = id_hold;
          job = 1;
          g = c + 1;
`ifdef TASK_SCHED_TIMEOUT_EN
          d = ($urandom_range(0, 3) == 0) ? TO : $urandom_range(1, TO + 3);
          if (d > TO) begin
            wl = -10; rel = g + TO + 1; to = 1;
          end else begin
            wl = g + d; rel = wl + 1; to = 0;
          end
`else
          d = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(1, 12);
          wl = g + d; rel = wl + 1; to = 0;
`endif
          idle_from = rel + 1;
        end
        if (job && c == wl)               out_last = 1'b1;
        else if (job && c > g && c < rel) out_last = 1'b0;
        else                              out_last = 1'($urandom);
      end
      t = c + 1;
      e = '0;
      e.gid = ID_W'(id_hold);
      if (!do_rst && job && t >= g && t <= rel) begin
        e.grant = (t < rel) ? N'(1) << id_hold : '0;
        e.start = (t == g);
        e.busy  = 1'b1;
        e.tmo   = to && (t == rel);
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
